// File: rtl/mem_loader_if.sv
// Byte-stream and memory-write bundle of mem_loader.
// slave is the loader side; master is the byte source / observer side.
interface mem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] mem_address;
  logic        mem_we;
  logic [31:0] mem_write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_address, mem_we, mem_write_data,
           busy, done, error, words_written
  );

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_address, mem_we, mem_write_data,
           busy, done, error, words_written
  );
endinterface

// File: rtl/mem_loader.sv
// Length-prefixed byte stream loader: packs bytes little-endian into words for memory_32bit.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input logic         clk,
  input logic         rst,
  mem_loader_if.slave bus
);

  // state  | meaning
  // IDLE   | waiting for start
  // LEN_LO | expecting low length byte
  // LEN_HI | expecting high length byte, length checked on transfer
  // DATA   | assembling a word, byte 0 lands in [7:0]
  // WRITE  | single-cycle memory write strobe
  // CHECK  | expecting trailing checksum byte
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHECK;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] index;
  logic [1:0]  byte_cnt;
  logic [23:0] word_asm;
  logic [15:0] len_word;
  logic        len_too_big;
  logic        last_word;
  logic        xfer;
  logic        ready_nxt;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign len_word    = {bus.byte_in, len_lo};
  assign len_too_big = {1'b0, len_word} > MAX_W;
  assign last_word   = ({1'b0, index} + 17'd1) >= {1'b0, n_words};
  assign xfer        = bus.byte_valid && (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
  assign ready_nxt   = state_nxt inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (len_too_big)           state_nxt = S_DONE;
          else if (len_word == '0)   state_nxt = END_STATE;
          else                       state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = last_word ? END_STATE : S_DATA;
      end
      S_CHECK: begin
        if (xfer) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake/status outputs are registered off the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.byte_ready     <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_we         <= 1'b0;
      bus.mem_write_data <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.error          <= 1'b0;
      bus.words_written  <= '0;
      len_lo             <= '0;
      n_words            <= '0;
      index              <= '0;
      byte_cnt           <= '0;
      word_asm           <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum               <= '0;
`endif
    end else begin
      bus.byte_ready <= ready_nxt;
      bus.mem_we     <= (state_nxt == S_WRITE);
      bus.busy       <= (state_nxt != S_IDLE);
      bus.done       <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.error         <= 1'b0;
            bus.words_written <= '0;
            index             <= '0;
            byte_cnt          <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            csum              <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (xfer) len_lo <= bus.byte_in;
        end
        S_LEN_HI: begin
          if (xfer) begin
            n_words <= len_word;
            if (len_too_big) bus.error <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_asm <= {bus.byte_in, word_asm[23:8]};
`ifdef MEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ bus.byte_in;
`endif
            if (byte_cnt == 2'd3) begin
              bus.mem_write_data <= {bus.byte_in, word_asm};
              bus.mem_address    <= BASE_ADDR + {16'h0000, index};
            end
          end
        end
        S_WRITE: begin
          index             <= index + 16'd1;
          bus.words_written <= bus.words_written + 16'd1;
        end
        S_CHECK: begin
`ifdef MEM_LOADER_CHECKSUM_EN
          if (xfer && bus.byte_in != csum) bus.error <= 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: frames are modelled as byte queues and the expected
// write list, done cycle, error and word count are derived from the frame contents.
module tb_mem_loader;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_000A;
  localparam int MAX = 256;
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          cyc;
    logic [31:0] idx;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  wr_t         exp_q[$];
  int          exp_done = -1;
  logic        exp_err = 1'b0;
  int          exp_words = 0;
  int          wr_cnt = 0;
  logic [31:0] last_addr_a = '0;
  logic [31:0] last_addr_b = '0;
  logic [31:0] last_data_a = '0;

  mem_loader_if if_a ();
  mem_loader_if if_b ();

  assign if_b.start      = if_a.start;
  assign if_b.byte_in    = if_a.byte_in;
  assign if_b.byte_valid = if_a.byte_valid;

  mem_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(MAX)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  mem_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(MAX)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Scoreboard: every write and every done pulse is checked against the frame model.
  wr_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (if_a.mem_we || if_b.mem_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d, no write required",
                   if_a.mem_address, if_a.mem_write_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
          chk("we_a", if_a.mem_we, 1);
          chk("we_b", if_b.mem_we, 1);
          chk("addr_a", if_a.mem_address, BASE_A + e.idx);
          chk("addr_b", if_b.mem_address, BASE_B + e.idx);
          chk("data_a", if_a.mem_write_data, e.data);
          chk("data_b", if_b.mem_write_data, e.data);
          last_addr_a = if_a.mem_address;
          last_addr_b = if_b.mem_address;
          last_data_a = if_a.mem_write_data;
        end
      end
      if (if_a.done || if_b.done) begin
        chk("done_cycle", 64'(cyc), 64'(exp_done));
        chk("done_b", if_b.done, 1);
        chk("error_a", if_a.error, exp_err);
        chk("error_b", if_b.error, exp_err);
        chk("words_a", if_a.words_written, 64'(exp_words));
        chk("words_b", if_b.words_written, 64'(exp_words));
        exp_done = -1;
      end
    end
  end

  function automatic bq_t mk_frame(input int n, input bq_t d, input bit bad);
    bq_t f;
    logic [7:0] x;
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    if (n <= MAX) begin
      x = 8'h00;
      foreach (d[i]) begin
        f.push_back(d[i]);
        x ^= d[i];
      end
      if (CSUM) f.push_back(bad ? ~x : x);
    end
    return f;
  endfunction

  function automatic bq_t rand_data(input int n);
    bq_t d;
    for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  // Called at a negedge with the loader idle; returns at a negedge after the last byte.
  // mode: 0 full rate, 1 valid every other cycle, 2 random stalls. limit >= 0 truncates.
  task automatic send_frame(input bq_t fr, input int mode, input bit junk_start, input int limit);
    int n, nb, p, guard, w, b;
    bit tog, v;
    logic [7:0] x;
    n = int'({fr[1], fr[0]});
    exp_words = (n > MAX) ? 0 : n;
    if (n > MAX) begin
      nb = 2;
      exp_err = 1'b1;
    end else begin
      nb = 2 + 4 * n + (CSUM ? 1 : 0);
      x = 8'h00;
      for (int i = 2; i < 2 + 4 * n; i++) x ^= fr[i];
      exp_err = CSUM ? (fr[nb-1] != x) : 1'b0;
    end
    if (limit >= 0 && limit < nb) nb = limit;

    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    chk("busy_after_start", if_a.busy, 1);
    chk("error_cleared", if_a.error, 0);
    chk("words_cleared", if_a.words_written, 0);

    p = 0;
    guard = 0;
    tog = 1'b0;
    while (p < nb) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
      tog = !tog;
      if_a.byte_valid = v;
      if_a.byte_in = v ? fr[p] : 8'($urandom);
      if (junk_start) if_a.start = ($urandom_range(0, 3) == 0);
      if (v && if_a.byte_ready) begin
        if (p == 1 && (n > MAX || (n == 0 && !CSUM))) exp_done = cyc + 1;
        if (p >= 2 && p < 2 + 4 * n && ((p - 2) % 4) == 3) begin
          w = (p - 2) / 4;
          b = 2 + 4 * w;
          e.cyc  = cyc + 1;
          e.idx  = 32'(w);
          e.data = {fr[b+3], fr[b+2], fr[b+1], fr[b]};
          exp_q.push_back(e);
          if (w == n - 1 && !CSUM) exp_done = cyc + 2;
        end
        if (CSUM && p == 2 + 4 * n) exp_done = cyc + 1;
        p++;
        guard = 0;
      end else begin
        guard++;
        if (guard > 100) begin
          n_total++;
          $display("FAIL byte_timeout: byte %0d of frame never accepted", p);
          break;
        end
      end
      @(negedge clk);
    end
    if_a.byte_valid = 1'b0;
    if_a.start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!if_a.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!if_a.done) begin
      n_total++;
      $display("FAIL done_timeout: no done pulse within %0d cycles", t);
    end
    @(negedge clk);
    chk("writes_drained", 64'(exp_q.size()), 0);
    chk("idle_busy", if_a.busy, 0);
    chk("idle_ready", if_a.byte_ready, 0);
    chk("sticky_error", if_a.error, exp_err);
  endtask

  bq_t d, fr;
  int  n;

  initial begin
    rst = 1'b1;
    if_a.start = 1'b0;
    if_a.byte_valid = 1'b0;
    if_a.byte_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", if_a.byte_ready, 0);
    chk("rst_mem_address", if_a.mem_address, 0);
    chk("rst_mem_we", if_a.mem_we, 0);
    chk("rst_mem_write_data", if_a.mem_write_data, 0);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_done", if_a.done, 0);
    chk("rst_error", if_a.error, 0);
    chk("rst_words", if_a.words_written, 0);
    rst = 1'b0;
    @(negedge clk);

    // Two words at full rate
    d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    wr_cnt = 0;
    send_frame(mk_frame(2, d, 1'b0), 0, 1'b0, -1);
    wait_done();
    chk("t1_writes", 64'(wr_cnt), 2);
    chk("t1_last_addr", last_addr_a, 32'h1);
    chk("t1_last_data", last_data_a, 32'h1234_5678);
    chk("t1_words", if_a.words_written, 2);
    chk("t1_error", if_a.error, 0);

    // One word with valid toggling; offset base on dut_b
    d = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    wr_cnt = 0;
    send_frame(mk_frame(1, d, 1'b0), 1, 1'b0, -1);
    wait_done();
    chk("t2_writes", 64'(wr_cnt), 1);
    chk("t2_addr_b", last_addr_b, 32'h0000_000A);
    chk("t2_data", last_data_a, 32'hAABB_CCDD);

    // Over-length frame is rejected without writes
    d.delete();
    wr_cnt = 0;
    send_frame(mk_frame(257, d, 1'b0), 0, 1'b0, -1);
    wait_done();
    chk("t3_writes", 64'(wr_cnt), 0);
    chk("t3_error", if_a.error, 1);
    chk("t3_words", if_a.words_written, 0);

    // CAFED00D, good then bad checksum (checksum byte only exists with the macro)
    d = '{8'h0D, 8'hD0, 8'hFE, 8'hCA};
    fr = mk_frame(1, d, 1'b0);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("t4_model_csum", fr[6], 8'hE9);
`endif
    send_frame(fr, 0, 1'b0, -1);
    wait_done();
    chk("t4_data", last_data_a, 32'hCAFE_D00D);
    chk("t4_error", if_a.error, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
    fr[6] = 8'h00;
    send_frame(fr, 2, 1'b0, -1);
    wait_done();
    chk("t4_bad_data", last_data_a, 32'hCAFE_D00D);
    chk("t4_bad_error", if_a.error, 1);
`endif

    // Reset two bytes into word 1 of a two-word frame
    wr_cnt = 0;
    send_frame(mk_frame(2, rand_data(2), 1'b0), 0, 1'b0, 8);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_writes_before_rst", 64'(wr_cnt), 1);
    chk("t5_busy", if_a.busy, 0);
    chk("t5_we", if_a.mem_we, 0);
    chk("t5_ready", if_a.byte_ready, 0);
    chk("t5_pending", 64'(exp_q.size()), 0);
    rst = 1'b0;
    exp_done = -1;
    @(negedge clk);
    d = '{8'h0D, 8'hF0, 8'h0D, 8'hF0};
    send_frame(mk_frame(1, d, 1'b0), 0, 1'b0, -1);
    wait_done();
    chk("t5_addr", last_addr_a, 32'h0);
    chk("t5_data", last_data_a, 32'hF00D_F00D);

    // Empty frame with start pulses while busy
    d.delete();
    wr_cnt = 0;
    send_frame(mk_frame(0, d, 1'b0), 0, 1'b1, -1);
    wait_done();
    chk("t6_writes", 64'(wr_cnt), 0);
    chk("t6_words", if_a.words_written, 0);
    chk("t6_error", if_a.error, 0);

    // Largest accepted length
    wr_cnt = 0;
    send_frame(mk_frame(256, rand_data(256), 1'b0), 0, 1'b0, -1);
    wait_done();
    chk("t7_writes", 64'(wr_cnt), 256);
    chk("t7_last_addr", last_addr_a, 32'd255);
    chk("t7_words", if_a.words_written, 256);

    // Random frames
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = 257 + $urandom_range(0, 1000);
        default: n = $urandom_range(1, 6);
      endcase
      d = (n > MAX) ? rand_data(0) : rand_data(n);
      send_frame(mk_frame(n, d, $urandom_range(0, 3) == 0), $urandom_range(0, 2),
                 $urandom_range(0, 1) == 1, -1);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
